// File: rtl/present_round_ctrl_pkg.sv
// Shared types and defaults for the PRESENT round sequencer.
package present_round_ctrl_pkg;

  localparam int unsigned ROUNDS_DEFAULT = 31;

  typedef enum logic [2:0] {
    IDLE,
    PREROLL,
    RUN,
    FINAL,
    HOLD
  } ctrl_state_t;

endpackage

// File: rtl/present_round_ctrl.sv
// Round sequencer for the PRESENT datapath: drives state/key write strobes and the
// round counter for encryption, and key pre-roll plus inverse rounds for decryption.
module present_round_ctrl
  import present_round_ctrl_pkg::*;
#(
  parameter  int unsigned ROUNDS = ROUNDS_DEFAULT,
  localparam int unsigned CNT_W  = $clog2(ROUNDS + 2)
) (
  input  logic             inClk,
  input  logic             inRstN,
  input  logic             inDataValid,
  output logic             outDataReady,
  input  logic             inDecrypt,
  input  logic             inKeyExtWr,
  output logic             outStateExtWr,
  output logic             outStateIntWr,
  output logic             outKeyExtWr,
  output logic             outKeyFwdWr,
  output logic             outKeyInvWr,
  output logic             outDataIntWr,
  output logic [CNT_W-1:0] outRoundCounter,
  output logic             outDecrypt,
  output logic             outBusy,
  output logic             outResultValid,
  input  logic             inResultReady
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS);

  ctrl_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             dec;
  logic             data_int_wr;
  logic             accept;
  logic             in_rounds;

  // Reset is folded into accept so no external-load strobe escapes while held in reset.
  assign accept    = inDataValid && (state == IDLE) && inRstN;
  assign in_rounds = (state == RUN) || (state == FINAL);

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state       <= IDLE;
      cnt         <= '0;
      dec         <= 1'b0;
      data_int_wr <= 1'b0;
    end else begin
      data_int_wr <= (state == FINAL);
      case (state)
        IDLE: begin
          if (accept) begin
            dec   <= inDecrypt;
            cnt   <= CNT_ONE;
            state <= inDecrypt ? PREROLL : RUN;
          end
        end
        PREROLL: begin
          // Counter parks at ROUNDS so the first inverse round reuses it.
          if (cnt == CNT_LAST) state <= RUN;
          else                 cnt   <= cnt + CNT_ONE;
        end
        RUN: begin
          if (dec) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_TWO) state <= FINAL;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_PEN) state <= FINAL;
          end
        end
        FINAL: state <= HOLD;
        HOLD: begin
          if (inResultReady) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign outDataReady    = (state == IDLE);
  assign outStateExtWr   = accept;
  assign outKeyExtWr     = accept && inKeyExtWr;
  assign outStateIntWr   = in_rounds;
  assign outKeyFwdWr     = (state == PREROLL) || (in_rounds && !dec);
  assign outKeyInvWr     = in_rounds && dec;
  assign outDataIntWr    = data_int_wr;
  assign outRoundCounter = cnt;
  assign outDecrypt      = dec;
  assign outBusy         = (state != IDLE);
  assign outResultValid  = (state == HOLD);

endmodule
